ccu_snoop_bcast: RTL and testbench
==================================

# ccu_snoop_bcast

CCU-side snoop broadcaster for the ACE coherency path. It accepts one snoop request for a cache line together with the index of the port that triggered it. It issues the snoop on the AC channel of every other core port and collects each port's CR response into one aggregated response. It then forwards the CD line data of one responding port and drains the CD data of any other responders. It sits between the CCU's request arbitration/dispatch stage and the per-core ACE snoop channels, and handles exactly one snoop at a time.

## Interface
Parameters:
- `NoPorts`, 4, number of core ports (≥1)
- `AxiAddrWidth`, 64, snoop address width
- `CdDataWidth`, 64, CD beat width
- `SrcW`, `max(1,$clog2(NoPorts))`, width of port index (derived)

Ports (clock and reset first; one clock; reset is asynchronous and active-low):
- `clk_i` in 1: clock
- `rst_ni` in 1: async active-low reset
- `snp_valid_i` in 1: snoop request valid
- `snp_ready_o` out 1: snoop request ready
- `snp_addr_i` in AxiAddrWidth: line address
- `snp_type_i` in 4: ACSNOOP code
- `snp_src_i` in SrcW: initiating port, never snooped
- `ac_valid_o` out NoPorts: per-port AC valid
- `ac_ready_i` in NoPorts: per-port AC ready
- `ac_addr_o` out AxiAddrWidth: registered address, shared by all ports
- `ac_snoop_o` out 4: registered ACSNOOP, shared by all ports
- `cr_valid_i` in NoPorts: CR valid
- `cr_ready_o` out NoPorts: CR ready
- `cr_resp_i` in NoPorts×5: {WasUnique, IsShared, PassDirty, Error, DataTransfer}
- `cd_valid_i` in NoPorts: CD valid
- `cd_ready_o` out NoPorts: CD ready
- `cd_data_i` in NoPorts×CdDataWidth: CD data
- `cd_last_i` in NoPorts: CD last beat
- `rsp_valid_o` out 1: aggregated response valid
- `rsp_ready_i` in 1: aggregated response ready
- `rsp_o` out 5: bitwise OR of all collected CR responses
- `data_valid_o` out 1: forwarded CD valid
- `data_ready_i` in 1: forwarded CD ready
- `data_o` out CdDataWidth: forwarded CD data
- `data_last_o` out 1: forwarded CD last beat

## Operation
- FSM states:
  - IDLE → SNOOP on `snp_valid_i & snp_ready_o`.
  - SNOOP → RESP when all targeted ports have completed both AC and CR.
  - RESP → DATA on `rsp` handshake if any target set DataTransfer; otherwise RESP → IDLE.
  - DATA → IDLE when every data-responding port has delivered its `cd_last_i` beat.
- `snp_ready_o` = (state==IDLE).
- On accept, register the address, the type and the target mask `tgt = ~onehot(snp_src_i)`.
- If `tgt`==0 (NoPorts==1), SNOOP passes directly to RESP with `rsp_o`=0.
- SNOOP, AC side:
  - `ac_valid_o[p]` = tgt[p] & ~ac_done[p].
  - `ac_done[p]` sets on the AC handshake. Ports complete independently. Once asserted, `ac_valid_o[p]` holds until `ac_ready_i[p]`.
- SNOOP, CR side:
  - `cr_ready_o[p]` = ac_done_q[p] & ~cr_done[p]. CR is accepted no earlier than the cycle after that port's AC handshake. `cr_valid_i` before that point is not acknowledged.
  - On each CR handshake, OR `cr_resp_i[p]` into the response register, set `cr_done[p]`, and set `dt[p]` = DataTransfer.
- RESP: `rsp_valid_o`=1 and `rsp_o` is held stable until `rsp_ready_i`.
- DATA:
  - `sel` = lowest-index p with `dt[p]`.
  - `data_valid_o`/`data_o`/`data_last_o` are combinational from `cd_*_i[sel]`, and `cd_ready_o[sel]` = `data_ready_i`.
  - For the other ports with `dt[p]`, `cd_ready_o[p]`=1 and their beats are discarded.
  - When a port's last beat is handshaken, its `dt` bit clears. Once `sel`'s bit clears, `data_valid_o` goes to 0 while the remaining ports drain.
- `cd_ready_o` is 0 outside DATA.
- CD beats never reach `data_o` unless they come from `sel`.

## Timing
- Reset (async, any state): state→IDLE; `ac_done`/`cr_done`/`dt`/rsp register cleared; `ac_valid_o`, `cr_ready_o`, `cd_ready_o`, `rsp_valid_o`, `data_valid_o` = 0; `snp_ready_o`=1. An in-flight snoop is abandoned.
- Snoop accepted at cycle 0 → `ac_valid_o` at cycle 1 (registered).
- Earliest CR handshake: cycle 2 (`ac_ready_i` high at cycle 1).
- `rsp_valid_o` asserts the cycle after the final CR handshake.
- DATA is entered the cycle after the `rsp` handshake.
- DATA passthrough has zero latency.
- Back-to-back snoops: IDLE lasts at least 1 cycle between snoops.
- Simultaneous events:
  - AC handshakes on several ports in one cycle are all recorded.
  - CR handshakes on several ports in one cycle are all ORed in.
  - Drain beats and `sel` beats may complete in the same cycle.

## Test plan
- NoPorts=4, src=1, all `ac_ready_i`=1, CR=0 from ports 0/2/3 at cycle 2 → `ac_valid_o`=4'b1101 for 1 cycle; `rsp_o`=0 at cycle 3; return to IDLE without DATA.
- src=0; port 3 holds `ac_ready_i` low for 5 cycles → `ac_valid_o[3]` stays high through that stall; `rsp_valid_o` only after port 3's CR.
- src=0; ports 2 and 3 return DataTransfer|PassDirty (5'b00101) → `rsp_o`=5'b00101. Port 2's 2 beats (0xA, 0xB, last on 0xB) appear on `data_o`; port 3's beats are drained and never visible.
- `cr_valid_i[1]` asserted in the same cycle as the AC handshake on port 1 → `cr_ready_o[1]`=0 that cycle and 1 in the next.
- NoPorts=1 snoop → no AC issued; `rsp_valid_o` with 0 two cycles after accept.
- `rst_ni` pulled low mid-DATA → all valids/readies drop immediately; `snp_ready_o`=1; a new snoop after reset completes normally.

Source files
------------

// File: rtl/ccu_snoop_bcast_if.sv
// Bundle of the snoop request, per-port ACE snoop channels and the aggregated outputs.
// The slave modport is the broadcaster's view; master is the surrounding environment.
interface ccu_snoop_bcast_if #(
    parameter int unsigned NoPorts      = 4,
    parameter int unsigned AxiAddrWidth = 64,
    parameter int unsigned CdDataWidth  = 64
);
    localparam int unsigned SrcW = (NoPorts > 1) ? $clog2(NoPorts) : 1;

    logic                                  snp_valid_i;
    logic                                  snp_ready_o;
    logic [AxiAddrWidth-1:0]               snp_addr_i;
    logic [3:0]                            snp_type_i;
    logic [SrcW-1:0]                       snp_src_i;
    logic [NoPorts-1:0]                    ac_valid_o;
    logic [NoPorts-1:0]                    ac_ready_i;
    logic [AxiAddrWidth-1:0]               ac_addr_o;
    logic [3:0]                            ac_snoop_o;
    logic [NoPorts-1:0]                    cr_valid_i;
    logic [NoPorts-1:0]                    cr_ready_o;
    logic [NoPorts-1:0][4:0]               cr_resp_i;
    logic [NoPorts-1:0]                    cd_valid_i;
    logic [NoPorts-1:0]                    cd_ready_o;
    logic [NoPorts-1:0][CdDataWidth-1:0]   cd_data_i;
    logic [NoPorts-1:0]                    cd_last_i;
    logic                                  rsp_valid_o;
    logic                                  rsp_ready_i;
    logic [4:0]                            rsp_o;
    logic                                  data_valid_o;
    logic                                  data_ready_i;
    logic [CdDataWidth-1:0]                data_o;
    logic                                  data_last_o;

    modport slave (
        input  snp_valid_i, snp_addr_i, snp_type_i, snp_src_i,
        input  ac_ready_i, cr_valid_i, cr_resp_i, cd_valid_i, cd_data_i, cd_last_i,
        input  rsp_ready_i, data_ready_i,
        output snp_ready_o, ac_valid_o, ac_addr_o, ac_snoop_o, cr_ready_o, cd_ready_o,
        output rsp_valid_o, rsp_o, data_valid_o, data_o, data_last_o
    );

    modport master (
        output snp_valid_i, snp_addr_i, snp_type_i, snp_src_i,
        output ac_ready_i, cr_valid_i, cr_resp_i, cd_valid_i, cd_data_i, cd_last_i,
        output rsp_ready_i, data_ready_i,
        input  snp_ready_o, ac_valid_o, ac_addr_o, ac_snoop_o, cr_ready_o, cd_ready_o,
        input  rsp_valid_o, rsp_o, data_valid_o, data_o, data_last_o
    );
endinterface

// File: rtl/ccu_snoop_bcast.sv
// Broadcasts one snoop to every non-initiating port, ORs the CR responses together and
// forwards one responder's CD data while draining the rest.
module ccu_snoop_bcast #(
    parameter int unsigned NoPorts      = 4,
    parameter int unsigned AxiAddrWidth = 64,
    parameter int unsigned CdDataWidth  = 64
) (
    input logic              clk_i,
    input logic              rst_ni,
    ccu_snoop_bcast_if.slave bus
);
    localparam int unsigned SrcW = (NoPorts > 1) ? $clog2(NoPorts) : 1;

    typedef enum logic [1:0] {StIdle, StSnoop, StResp, StData} state_e;

    state_e                  state_q, state_d;
    logic [AxiAddrWidth-1:0] addr_q, addr_d;
    logic [3:0]              type_q, type_d;
    logic [NoPorts-1:0]      tgt_q, tgt_d;
    logic [NoPorts-1:0]      ac_done_q, ac_done_d;
    logic [NoPorts-1:0]      cr_done_q, cr_done_d;
    logic [NoPorts-1:0]      dt_q, dt_d;
    logic [4:0]              rsp_q, rsp_d;
    logic [SrcW-1:0]         sel_q, sel_d, sel_lo;

    logic [NoPorts-1:0]      ac_valid, cr_ready, cd_ready;
    logic [NoPorts-1:0]      ac_hs, cr_hs, cd_last_hs;

    always_comb begin
        ac_valid = '0;
        cr_ready = '0;
        cd_ready = '0;
        case (state_q)
            StSnoop: begin
                ac_valid = tgt_q & ~ac_done_q;
                cr_ready = ac_done_q & ~cr_done_q;
            end
            StData: begin
                // Non-selected responders are drained unconditionally.
                cd_ready        = dt_q;
                cd_ready[sel_q] = dt_q[sel_q] & bus.data_ready_i;
            end
            default: ;
        endcase
    end

    assign ac_hs      = ac_valid & bus.ac_ready_i;
    assign cr_hs      = bus.cr_valid_i & cr_ready;
    assign cd_last_hs = bus.cd_valid_i & cd_ready & bus.cd_last_i;

    always_comb begin
        sel_lo = '0;
        for (int p = int'(NoPorts) - 1; p >= 0; p--) begin
            if (dt_q[p]) sel_lo = SrcW'(p);
        end
    end

    assign bus.snp_ready_o  = (state_q == StIdle);
    assign bus.ac_valid_o   = ac_valid;
    assign bus.ac_addr_o    = addr_q;
    assign bus.ac_snoop_o   = type_q;
    assign bus.cr_ready_o   = cr_ready;
    assign bus.cd_ready_o   = cd_ready;
    assign bus.rsp_valid_o  = (state_q == StResp);
    assign bus.rsp_o        = rsp_q;
    assign bus.data_valid_o = (state_q == StData) & dt_q[sel_q] & bus.cd_valid_i[sel_q];
    assign bus.data_o       = bus.cd_data_i[sel_q];
    assign bus.data_last_o  = bus.cd_last_i[sel_q];

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        type_d    = type_q;
        tgt_d     = tgt_q;
        ac_done_d = ac_done_q | ac_hs;
        cr_done_d = cr_done_q | cr_hs;
        dt_d      = dt_q & ~cd_last_hs;
        rsp_d     = rsp_q;
        sel_d     = sel_q;

        for (int p = 0; p < int'(NoPorts); p++) begin
            if (cr_hs[p]) begin
                rsp_d   = rsp_d | bus.cr_resp_i[p];
                dt_d[p] = bus.cr_resp_i[p][0];
            end
        end

        case (state_q)
            StIdle: begin
                if (bus.snp_valid_i) begin
                    state_d   = StSnoop;
                    addr_d    = bus.snp_addr_i;
                    type_d    = bus.snp_type_i;
                    ac_done_d = '0;
                    cr_done_d = '0;
                    dt_d      = '0;
                    rsp_d     = '0;
                    for (int p = 0; p < int'(NoPorts); p++) begin
                        tgt_d[p] = (SrcW'(p) != bus.snp_src_i);
                    end
                end
            end
            StSnoop: begin
                // An empty target set falls straight through with a zero response.
                if ((cr_done_d & tgt_q) == tgt_q) state_d = StResp;
            end
            StResp: begin
                if (bus.rsp_ready_i) begin
                    sel_d   = sel_lo;
                    state_d = (|dt_q) ? StData : StIdle;
                end
            end
            StData: begin
                if (dt_d == '0) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            type_q    <= '0;
            tgt_q     <= '0;
            ac_done_q <= '0;
            cr_done_q <= '0;
            dt_q      <= '0;
            rsp_q     <= '0;
            sel_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            type_q    <= type_d;
            tgt_q     <= tgt_d;
            ac_done_q <= ac_done_d;
            cr_done_q <= cr_done_d;
            dt_q      <= dt_d;
            rsp_q     <= rsp_d;
            sel_q     <= sel_d;
        end
    end
endmodule

// File: tb/tb_ccu_snoop_bcast.sv
// Directed bench for ccu_snoop_bcast: a 4-port instance for the main scenarios and a
// 1-port instance for the empty-target case.
module tb_ccu_snoop_bcast;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   ntests = 0;
    int   nfail = 0;

    always #5 clk = ~clk;

    ccu_snoop_bcast_if #(.NoPorts(4), .AxiAddrWidth(64), .CdDataWidth(64)) bus4 ();
    ccu_snoop_bcast_if #(.NoPorts(1), .AxiAddrWidth(32), .CdDataWidth(8))  bus1 ();

    ccu_snoop_bcast #(.NoPorts(4), .AxiAddrWidth(64), .CdDataWidth(64)) u_dut4 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus4)
    );

    ccu_snoop_bcast #(.NoPorts(1), .AxiAddrWidth(32), .CdDataWidth(8)) u_dut1 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        bus4.snp_valid_i  = 1'b0;
        bus4.snp_addr_i   = '0;
        bus4.snp_type_i   = '0;
        bus4.snp_src_i    = '0;
        bus4.ac_ready_i   = '0;
        bus4.cr_valid_i   = '0;
        bus4.cr_resp_i    = '0;
        bus4.cd_valid_i   = '0;
        bus4.cd_data_i    = '0;
        bus4.cd_last_i    = '0;
        bus4.rsp_ready_i  = 1'b0;
        bus4.data_ready_i = 1'b0;
        bus1.snp_valid_i  = 1'b0;
        bus1.snp_addr_i   = '0;
        bus1.snp_type_i   = '0;
        bus1.snp_src_i    = '0;
        bus1.ac_ready_i   = '0;
        bus1.cr_valid_i   = '0;
        bus1.cr_resp_i    = '0;
        bus1.cd_valid_i   = '0;
        bus1.cd_data_i    = '0;
        bus1.cd_last_i    = '0;
        bus1.rsp_ready_i  = 1'b0;
        bus1.data_ready_i = 1'b0;
    endtask

    initial begin
        clear_inputs();
        tick();
        tick();
        // Reset state
        chk("rst_snp_ready", bus4.snp_ready_o, 1);
        chk("rst_ac_valid", bus4.ac_valid_o, 0);
        chk("rst_cr_ready", bus4.cr_ready_o, 0);
        chk("rst_cd_ready", bus4.cd_ready_o, 0);
        chk("rst_rsp_valid", bus4.rsp_valid_o, 0);
        chk("rst_data_valid", bus4.data_valid_o, 0);
        rst_n = 1'b1;

        // Scenario 1: src=1, all AC ready, zero CR from ports 0/2/3
        tick();
        bus4.snp_valid_i = 1'b1;
        bus4.snp_src_i   = 2'd1;
        bus4.snp_addr_i  = 64'h1000;
        bus4.snp_type_i  = 4'h7;
        settle();
        chk("s1_snp_ready_c0", bus4.snp_ready_o, 1);
        tick();
        bus4.snp_valid_i = 1'b0;
        bus4.ac_ready_i  = 4'hF;
        settle();
        chk("s1_ac_valid_c1", bus4.ac_valid_o, 4'b1101);
        chk("s1_ac_addr", bus4.ac_addr_o, 64'h1000);
        chk("s1_ac_snoop", bus4.ac_snoop_o, 4'h7);
        chk("s1_snp_ready_c1", bus4.snp_ready_o, 0);
        chk("s1_cr_ready_c1", bus4.cr_ready_o, 0);
        tick();
        bus4.cr_valid_i = 4'b1101;
        settle();
        chk("s1_ac_valid_c2", bus4.ac_valid_o, 0);
        chk("s1_cr_ready_c2", bus4.cr_ready_o, 4'b1101);
        tick();
        bus4.cr_valid_i  = '0;
        bus4.rsp_ready_i = 1'b1;
        settle();
        chk("s1_rsp_valid_c3", bus4.rsp_valid_o, 1);
        chk("s1_rsp_c3", bus4.rsp_o, 5'b00000);
        tick();
        bus4.rsp_ready_i = 1'b0;
        settle();
        chk("s1_idle_c4", bus4.snp_ready_o, 1);
        chk("s1_no_data_c4", bus4.data_valid_o, 0);
        chk("s1_cd_ready_c4", bus4.cd_ready_o, 0);

        // Scenario 2: src=0, port 3 stalls AC for 5 cycles
        tick();
        bus4.snp_valid_i = 1'b1;
        bus4.snp_src_i   = 2'd0;
        bus4.snp_addr_i  = 64'h2040;
        bus4.snp_type_i  = 4'hB;
        bus4.ac_ready_i  = 4'b0111;
        tick();
        bus4.snp_valid_i = 1'b0;
        settle();
        chk("s2_ac_valid_c1", bus4.ac_valid_o, 4'b1110);
        tick();
        bus4.cr_valid_i   = 4'b0110;
        bus4.cr_resp_i[1] = 5'b01000;
        bus4.cr_resp_i[2] = 5'b00000;
        settle();
        chk("s2_ac_valid_c2", bus4.ac_valid_o, 4'b1000);
        chk("s2_cr_ready_c2", bus4.cr_ready_o, 4'b0110);
        tick();
        bus4.cr_valid_i = '0;
        settle();
        chk("s2_ac3_stall_c3", bus4.ac_valid_o, 4'b1000);
        chk("s2_no_rsp_c3", bus4.rsp_valid_o, 0);
        for (int c = 4; c <= 5; c++) begin
            tick();
            settle();
            chk("s2_ac3_stall", bus4.ac_valid_o, 4'b1000);
        end
        tick();
        bus4.ac_ready_i = 4'hF;
        settle();
        chk("s2_ac3_c6", bus4.ac_valid_o, 4'b1000);
        tick();
        bus4.cr_valid_i   = 4'b1000;
        bus4.cr_resp_i[3] = 5'b10000;
        settle();
        chk("s2_ac_valid_c7", bus4.ac_valid_o, 0);
        chk("s2_cr_ready_c7", bus4.cr_ready_o, 4'b1000);
        chk("s2_no_rsp_c7", bus4.rsp_valid_o, 0);
        tick();
        bus4.cr_valid_i  = '0;
        bus4.rsp_ready_i = 1'b1;
        settle();
        chk("s2_rsp_valid_c8", bus4.rsp_valid_o, 1);
        chk("s2_rsp_c8", bus4.rsp_o, 5'b11000);
        tick();
        bus4.rsp_ready_i = 1'b0;
        bus4.cr_resp_i   = '0;
        settle();
        chk("s2_idle_c9", bus4.snp_ready_o, 1);

        // Scenario 3: src=0, early CR on port 1, ports 2/3 return DataTransfer|PassDirty
        tick();
        bus4.snp_valid_i = 1'b1;
        bus4.snp_src_i   = 2'd0;
        bus4.snp_addr_i  = 64'h3080;
        bus4.snp_type_i  = 4'h1;
        tick();
        bus4.snp_valid_i  = 1'b0;
        bus4.ac_ready_i   = 4'hF;
        bus4.cr_valid_i   = 4'b1110;
        bus4.cr_resp_i[1] = 5'b00000;
        bus4.cr_resp_i[2] = 5'b00101;
        bus4.cr_resp_i[3] = 5'b00101;
        settle();
        chk("s3_cr_ready_at_ac_hs", bus4.cr_ready_o, 4'b0000);
        tick();
        settle();
        chk("s3_cr_ready_after_ac", bus4.cr_ready_o, 4'b1110);
        tick();
        bus4.cr_valid_i  = '0;
        bus4.cr_resp_i   = '0;
        bus4.rsp_ready_i = 1'b1;
        settle();
        chk("s3_rsp_valid", bus4.rsp_valid_o, 1);
        chk("s3_rsp", bus4.rsp_o, 5'b00101);
        tick();
        // DATA c4: sink stalls, port 3 drains
        bus4.rsp_ready_i  = 1'b0;
        bus4.data_ready_i = 1'b0;
        bus4.cd_valid_i   = 4'b1100;
        bus4.cd_data_i[2] = 64'hA;
        bus4.cd_data_i[3] = 64'h33;
        bus4.cd_last_i    = 4'b0000;
        settle();
        chk("s3_rsp_gone", bus4.rsp_valid_o, 0);
        chk("s3_dv_stall", bus4.data_valid_o, 1);
        chk("s3_data_a_stall", bus4.data_o, 64'hA);
        chk("s3_cd_ready_stall", bus4.cd_ready_o, 4'b1000);
        tick();
        bus4.data_ready_i = 1'b1;
        bus4.cd_data_i[3] = 64'h34;
        settle();
        chk("s3_data_a", bus4.data_o, 64'hA);
        chk("s3_last_a", bus4.data_last_o, 0);
        chk("s3_cd_ready_both", bus4.cd_ready_o, 4'b1100);
        tick();
        bus4.cd_data_i[2] = 64'hB;
        bus4.cd_data_i[3] = 64'h35;
        bus4.cd_last_i    = 4'b0100;
        settle();
        chk("s3_data_b", bus4.data_o, 64'hB);
        chk("s3_last_b", bus4.data_last_o, 1);
        chk("s3_dv_b", bus4.data_valid_o, 1);
        tick();
        bus4.cd_data_i[2] = 64'hDEAD;
        bus4.cd_data_i[3] = 64'h36;
        bus4.cd_last_i    = 4'b1000;
        settle();
        chk("s3_dv_after_sel", bus4.data_valid_o, 0);
        chk("s3_drain_only", bus4.cd_ready_o, 4'b1000);
        tick();
        bus4.cd_valid_i   = '0;
        bus4.cd_last_i    = '0;
        bus4.cd_data_i    = '0;
        bus4.data_ready_i = 1'b0;
        settle();
        chk("s3_idle", bus4.snp_ready_o, 1);
        chk("s3_cd_ready_idle", bus4.cd_ready_o, 0);

        // Scenario 4: async reset in the middle of DATA, then a clean snoop
        tick();
        bus4.snp_valid_i = 1'b1;
        bus4.snp_src_i   = 2'd3;
        bus4.snp_addr_i  = 64'h4000;
        tick();
        bus4.snp_valid_i = 1'b0;
        bus4.ac_ready_i  = 4'hF;
        tick();
        bus4.cr_valid_i   = 4'b0111;
        bus4.cr_resp_i[0] = 5'b00001;
        tick();
        bus4.cr_valid_i  = '0;
        bus4.cr_resp_i   = '0;
        bus4.rsp_ready_i = 1'b1;
        settle();
        chk("s4_rsp", bus4.rsp_o, 5'b00001);
        tick();
        bus4.rsp_ready_i  = 1'b0;
        bus4.cd_valid_i   = 4'b0001;
        bus4.cd_data_i[0] = 64'h55;
        bus4.data_ready_i = 1'b1;
        settle();
        chk("s4_dv_pre_rst", bus4.data_valid_o, 1);
        chk("s4_data_pre_rst", bus4.data_o, 64'h55);
        rst_n = 1'b0;
        settle();
        chk("s4_dv_rst", bus4.data_valid_o, 0);
        chk("s4_cd_ready_rst", bus4.cd_ready_o, 0);
        chk("s4_snp_ready_rst", bus4.snp_ready_o, 1);
        chk("s4_rsp_valid_rst", bus4.rsp_valid_o, 0);
        chk("s4_rsp_rst", bus4.rsp_o, 0);
        clear_inputs();
        tick();
        rst_n = 1'b1;
        tick();
        bus4.snp_valid_i = 1'b1;
        bus4.snp_src_i   = 2'd2;
        bus4.snp_addr_i  = 64'h5000;
        tick();
        bus4.snp_valid_i = 1'b0;
        bus4.ac_ready_i  = 4'hF;
        settle();
        chk("s4_post_ac_valid", bus4.ac_valid_o, 4'b1011);
        tick();
        bus4.cr_valid_i = 4'b1011;
        tick();
        bus4.cr_valid_i  = '0;
        bus4.rsp_ready_i = 1'b1;
        settle();
        chk("s4_post_rsp_valid", bus4.rsp_valid_o, 1);
        chk("s4_post_rsp", bus4.rsp_o, 0);
        tick();
        bus4.rsp_ready_i = 1'b0;
        settle();
        chk("s4_post_idle", bus4.snp_ready_o, 1);

        // Scenario 5: single-port instance, nothing to snoop
        tick();
        bus1.snp_valid_i = 1'b1;
        bus1.snp_src_i   = 1'b0;
        bus1.snp_addr_i  = 32'h600;
        tick();
        bus1.snp_valid_i = 1'b0;
        bus1.ac_ready_i  = 1'b1;
        settle();
        chk("s5_ac_valid_c1", bus1.ac_valid_o, 0);
        chk("s5_rsp_valid_c1", bus1.rsp_valid_o, 0);
        chk("s5_snp_ready_c1", bus1.snp_ready_o, 0);
        tick();
        bus1.rsp_ready_i = 1'b1;
        settle();
        chk("s5_rsp_valid_c2", bus1.rsp_valid_o, 1);
        chk("s5_rsp_c2", bus1.rsp_o, 0);
        chk("s5_ac_valid_c2", bus1.ac_valid_o, 0);
        tick();
        bus1.rsp_ready_i = 1'b0;
        settle();
        chk("s5_idle", bus1.snp_ready_o, 1);
        chk("s5_no_data", bus1.data_valid_o, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
